// File: rtl/sprite_loader_if.sv
`default_nettype none
//==============================================================================
// Module      : sprite_loader_if
// Description : Pixel stream (valid/ready) plus image-RAM port A write bus
//               between a pixel source and the sprite loader.
// Revision    : 1.0 - initial release
//==============================================================================
interface sprite_loader_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Pixel source / write-bus observer side
    modport master (
        output in_data, in_valid,
        input  in_ready, we, waddr, wdata
    );

    // Loader side: consumes the stream, drives the RAM write port
    modport slave (
        input  in_data, in_valid,
        output in_ready, we, waddr, wdata
    );
endinterface
`default_nettype wire

// File: rtl/sprite_loader.sv
`default_nettype none
//==============================================================================
// Module      : sprite_loader
// Description : Loads a raster-ordered palette-index stream into the sprite
//               image RAM (port A), generating addr = row*WIDTH + col with a
//               plain incrementing counter. start/done sequencing, err pulse
//               on an ignored start.
//               Optional: define SPRITE_LOADER_CHECKSUM_EN to add a 16-bit
//               running sum of the accepted pixels as output `checksum`.
// Revision    : 1.0 - initial release
//==============================================================================
module sprite_loader #(
    parameter int WIDTH  = 315,
    parameter int HEIGHT = 262,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         start,
    sprite_loader_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef SPRITE_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int c_COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int c_ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(HEIGHT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_start_ok;   // start accepted in IDLE
    logic                w_beat;       // pixel accepted this cycle
    logic                w_last;       // final pixel of the image
    logic                w_err;        // start ignored during LOAD

    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;
    logic                r_err;

    // State register; reset forces IDLE immediately so busy/in_ready drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_beat       = 1'b0;
        w_last       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_err  = start;
                w_beat = bus.in_valid;
                w_last = bus.in_valid && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
                if (w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Raster counters and registered RAM write port / status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= w_beat;
            r_done <= w_last;
            r_err  <= w_err;
            if (w_start_ok) begin
                r_col  <= '0;
                r_row  <= '0;
                r_addr <= '0;
            end else if (w_beat) begin
                r_waddr <= r_addr;
                r_wdata <= bus.in_data;
                if (w_last) begin
                    // Park counters at the origin so row never overflows its width
                    r_col  <= '0;
                    r_row  <= '0;
                    r_addr <= '0;
                end else if (r_col == c_COL_LAST) begin
                    r_col  <= '0;
                    r_row  <= r_row + c_ROW_W'(1);
                    r_addr <= r_addr + ADDR_W'(1);
                end else begin
                    r_col  <= r_col + c_COL_W'(1);
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running mod-2^16 sum of accepted pixels; holds after done until next start
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           r_checksum <= '0;
        else if (w_start_ok) r_checksum <= '0;
        else if (w_beat)     r_checksum <= r_checksum + 16'(bus.in_data);
    end

    assign checksum = r_checksum;
`endif

    assign bus.in_ready = (r_state == S_LOAD);
    assign busy         = (r_state == S_LOAD);
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sprite_loader.sv
`default_nettype none
//==============================================================================
// Module      : tb_sprite_loader
// Description : Directed self-checking bench for sprite_loader, 4x3 image.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_sprite_loader;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic err;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    sprite_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_loader #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (bus.slave),
        .busy    (busy),
        .done    (done),
        .err     (err)
`ifdef SPRITE_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Observed write log, filled at every falling edge
    typedef struct {
        int addr;
        int data;
        bit dn;
        int cyc;
    } wr_t;
    wr_t log_q[$];
    int  cyc      = 0;
    int  done_cnt = 0;
    int  err_cnt  = 0;

    always @(negedge clk) begin
        wr_t e;
        cyc = cyc + 1;
        if (bus.we === 1'b1) begin
            e.addr = int'(bus.waddr);
            e.data = int'(bus.wdata);
            e.dn   = (done === 1'b1);
            e.cyc  = cyc;
            log_q.push_back(e);
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (err === 1'b1)  err_cnt  = err_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus helpers (drive only, no checking); all return on a falling edge
    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int base, input int incr, input bit gap);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(base + i * incr);
            @(negedge clk);
            if (gap) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic settle;
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clear_log;
        log_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_chk++; if (bus.we !== 1'b0)       begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.we); end
        n_chk++; if (bus.waddr !== '0)      begin n_fail++; $display("FAIL rst_waddr: got %0d want 0", bus.waddr); end
        n_chk++; if (bus.wdata !== '0)      begin n_fail++; $display("FAIL rst_wdata: got %0h want 0", bus.wdata); end
        n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0)         begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_chk++; if (err !== 1'b0)          begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
`ifdef SPRITE_LOADER_CHECKSUM_EN
        n_chk++; if (checksum !== 16'h0)    begin n_fail++; $display("FAIL rst_checksum: got %h want 0000", checksum); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        clear_log();
        pulse_start();
        n_chk++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL b2b_busy_start: got %b want 1", busy); end
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_start: got %b want 1", bus.in_ready); end
        send_beats(12, 8'h10, 1, 1'b0);
        n_chk++; if (done !== 1'b1)         begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
        n_chk++; if (bus.waddr !== 17'd11)  begin n_fail++; $display("FAIL b2b_done_addr: got %0d want 11", bus.waddr); end
        n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_end: got %b want 0", bus.in_ready); end
        @(negedge clk);
        n_chk++; if (done !== 1'b0)         begin n_fail++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
        n_chk++; if (bus.we !== 1'b0)       begin n_fail++; $display("FAIL b2b_we_after: got %b want 0", bus.we); end
        settle();
        n_chk++; if (log_q.size() != 12)    begin n_fail++; $display("FAIL b2b_count: got %0d want 12", log_q.size()); end
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            n_chk++;
            if (log_q[i].addr != i || log_q[i].data != 8'h10 + i || log_q[i].dn != (i == 11) ||
                log_q[i].cyc != log_q[0].cyc + i) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got addr %0d data %0h done %0d cyc+%0d want addr %0d data %0h done %0d cyc+%0d",
                         i, log_q[i].addr, log_q[i].data, log_q[i].dn, log_q[i].cyc - log_q[0].cyc,
                         i, 8'h10 + i, (i == 11), i);
            end
        end
        n_chk++; if (done_cnt != 1)         begin n_fail++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_gaps;
        clear_log();
        pulse_start();
        send_beats(12, 8'h10, 1, 1'b1);
        settle();
        n_chk++; if (log_q.size() != 12)    begin n_fail++; $display("FAIL gap_count: got %0d want 12", log_q.size()); end
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            n_chk++;
            if (log_q[i].addr != i || log_q[i].data != 8'h10 + i || log_q[i].dn != (i == 11) ||
                log_q[i].cyc != log_q[0].cyc + 2 * i) begin
                n_fail++;
                $display("FAIL gap_write%0d: got addr %0d data %0h done %0d cyc+%0d want addr %0d data %0h done %0d cyc+%0d",
                         i, log_q[i].addr, log_q[i].data, log_q[i].dn, log_q[i].cyc - log_q[0].cyc,
                         i, 8'h10 + i, (i == 11), 2 * i);
            end
        end
        n_chk++; if (done_cnt != 1)         begin n_fail++; $display("FAIL gap_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_restart_err;
        clear_log();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h20 + i);
            start        = (i == 5);
            @(negedge clk);
            start = 1'b0;
            if (i == 5) begin
                n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL rs_err: got %b want 1", err); end
            end
            if (i == 6) begin
                n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rs_err_pulse: got %b want 0", err); end
            end
        end
        bus.in_valid = 1'b0;
        n_chk++; if (done !== 1'b1)         begin n_fail++; $display("FAIL rs_done: got %b want 1", done); end
        settle();
        n_chk++; if (log_q.size() != 12)    begin n_fail++; $display("FAIL rs_count: got %0d want 12", log_q.size()); end
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            n_chk++;
            if (log_q[i].addr != i || log_q[i].data != 8'h20 + i) begin
                n_fail++;
                $display("FAIL rs_write%0d: got addr %0d data %0h want addr %0d data %0h",
                         i, log_q[i].addr, log_q[i].data, i, 8'h20 + i);
            end
        end
        n_chk++; if (done_cnt != 1)         begin n_fail++; $display("FAIL rs_done_cnt: got %0d want 1", done_cnt); end
        n_chk++; if (err_cnt != 1)          begin n_fail++; $display("FAIL rs_err_cnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_mid_reset;
        clear_log();
        pulse_start();
        send_beats(7, 8'h30, 1, 1'b0);
        n_chk++; if (bus.we !== 1'b1 || bus.waddr !== 17'd6) begin
            n_fail++; $display("FAIL mr_pre_write: got we %b addr %0d want we 1 addr 6", bus.we, bus.waddr);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++; if (bus.we !== 1'b0)       begin n_fail++; $display("FAIL mr_we: got %b want 0", bus.we); end
        n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL mr_busy: got %b want 0", busy); end
        n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_beats(12, 8'h40, 1, 1'b0);
        n_chk++; if (done !== 1'b1)         begin n_fail++; $display("FAIL mr_done: got %b want 1", done); end
        settle();
        n_chk++; if (log_q.size() != 12)    begin n_fail++; $display("FAIL mr_count: got %0d want 12", log_q.size()); end
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            n_chk++;
            if (log_q[i].addr != i || log_q[i].data != 8'h40 + i) begin
                n_fail++;
                $display("FAIL mr_write%0d: got addr %0d data %0h want addr %0d data %0h",
                         i, log_q[i].addr, log_q[i].data, i, 8'h40 + i);
            end
        end
    endtask

    task automatic test_back_to_back_loads;
        clear_log();
        pulse_start();
        send_beats(12, 8'h50, 1, 1'b0);
        n_chk++; if (done !== 1'b1)         begin n_fail++; $display("FAIL bl_done1: got %b want 1", done); end
        pulse_start();
        n_chk++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL bl_busy2: got %b want 1", busy); end
        n_chk++; if (err !== 1'b0)          begin n_fail++; $display("FAIL bl_err2: got %b want 0", err); end
        send_beats(12, 8'h60, 1, 1'b0);
        n_chk++; if (done !== 1'b1)         begin n_fail++; $display("FAIL bl_done2: got %b want 1", done); end
        // Stream presented while idle must be refused
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (bus.in_ready !== 1'b0 || bus.we !== 1'b0) begin
                n_fail++; $display("FAIL bl_idle%0d: got ready %b we %b want 0 0", i, bus.in_ready, bus.we);
            end
        end
        bus.in_valid = 1'b0;
        settle();
        n_chk++; if (log_q.size() != 24)    begin n_fail++; $display("FAIL bl_count: got %0d want 24", log_q.size()); end
        for (int i = 0; i < 12 && i + 12 < log_q.size(); i++) begin
            n_chk++;
            if (log_q[i + 12].addr != i || log_q[i + 12].data != 8'h60 + i) begin
                n_fail++;
                $display("FAIL bl_write%0d: got addr %0d data %0h want addr %0d data %0h",
                         i, log_q[i + 12].addr, log_q[i + 12].data, i, 8'h60 + i);
            end
        end
        n_chk++; if (done_cnt != 2)         begin n_fail++; $display("FAIL bl_done_cnt: got %0d want 2", done_cnt); end
        n_chk++; if (err_cnt != 0)          begin n_fail++; $display("FAIL bl_err_cnt: got %0d want 0", err_cnt); end
    endtask

`ifdef SPRITE_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_start();
        n_chk++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL cs_clear: got %h want 0000", checksum); end
        send_beats(12, 8'hFF, 0, 1'b0);
        n_chk++; if (checksum !== 16'h0BF4) begin n_fail++; $display("FAIL cs_done: got %h want 0bf4", checksum); end
        repeat (3) @(negedge clk);
        n_chk++; if (checksum !== 16'h0BF4) begin n_fail++; $display("FAIL cs_hold: got %h want 0bf4", checksum); end
    endtask
`endif

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_restart_err();
        test_mid_reset();
        test_back_to_back_loads();
`ifdef SPRITE_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_loader.md
# sprite_loader

Writes a palette-indexed sprite image into the dual-port image RAM that the sprite display blocks read from. It accepts a raster-ordered byte stream (row 0 column 0 first) over a valid/ready handshake and generates the linear write address `row*WIDTH + col`. Writes go to port A of the image RAM, so display reads on the other port continue undisturbed. The sequencer starts a load on a `start` pulse and ends it with a `done` pulse.

## Interface
Parameters:
- `WIDTH`, 315, sprite width in pixels.
- `HEIGHT`, 262, sprite height in pixels.
- `ADDR_W`, 17, RAM address width; `WIDTH*HEIGHT` must be ≤ 2^ADDR_W.
- `DATA_W`, 8, palette index width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse to begin a load.
- `in_data`  in  DATA_W  palette index of the current pixel.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a beat this cycle.
- `we`  out  1  RAM write enable (registered).
- `waddr`  out  ADDR_W  RAM write address (registered).
- `wdata`  out  DATA_W  RAM write data (registered).
- `busy`  out  1  high while in LOAD.
- `done`  out  1  one-cycle pulse on the final write.
- `err`  out  1  one-cycle pulse when `start` is ignored.

## Operation
- States are IDLE and LOAD.
- IDLE:
  - `in_ready=0`.
  - On `start`, clear `col`, `row` and `addr`, then go to LOAD.
- LOAD:
  - `in_ready=1` and `busy=1`.
  - Each accepted beat (`in_valid & in_ready`) registers `we=1`, `waddr=addr` and `wdata=in_data`.
  - After each beat: `addr <= addr+1` and `col <= col+1`.
  - When `col==WIDTH-1`: `col <= 0` and `row <= row+1`.
- The address is an incrementing counter; no multiplier is used. `addr` always equals `row*WIDTH+col`.
- Final beat (`row==HEIGHT-1 && col==WIDTH-1`): go to IDLE and register `done=1` alongside that write.
- Cycles without a beat (`in_valid=0`) register `we=0`. Counters hold.
- `start` during LOAD is ignored and registers `err=1` for one cycle. The load continues unchanged.
- `start` in IDLE and `start` in the same cycle as `done` are both legal. A `start` coincident with the `done` output cycle begins a new load.
- `in_valid` in IDLE is not accepted and causes no write.
- Reset mid-load:
  - The state returns to IDLE immediately.
  - `we`, `done`, `err`, `busy` and `in_ready` drop asynchronously.
  - Counters clear to 0.
  - RAM contents already written are left as-is.

## Timing
- Reset values: `in_ready=0`, `we=0`, `waddr=0`, `wdata=0`, `busy=0`, `done=0`, `err=0`; state IDLE.
- `start` sampled at edge N gives `busy=1` and `in_ready=1` from cycle N+1.
- A beat accepted at edge K appears on `we`/`waddr`/`wdata` during cycle K+1. Write latency is 1 cycle.
- Sustained throughput is 1 pixel per clock. A full image takes `WIDTH*HEIGHT` accepted beats.
- Final beat at edge K: `done=1` during cycle K+1, and `busy=0` and `in_ready=0` from cycle K+1.
- `err` appears one cycle after the offending `start`.

## Configuration
- `SPRITE_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum[15:0]`.
  - `checksum` is the mod-2^16 sum of all accepted `in_data` bytes, zero-extended, for the current load.
  - It clears on the `start` that begins a load and updates one cycle after each beat.
  - It is final and stable from the `done` cycle until the next accepted `start`.
  - Reset value is 0.
- Not defined: the port and the adder are absent, and behaviour is otherwise identical.

## Test plan
All scenarios use `WIDTH=4`, `HEIGHT=3`.
- Reset then `start`, 12 back-to-back beats with data 0x10..0x1B -> writes to addresses 0..11 with matching data on consecutive cycles; `done` coincides with the address-11 write; `in_ready=0` the next cycle.
- Same stream with `in_valid` low on every other cycle -> 12 writes, addresses 0..11 in order, no writes in gaps; `done` on the write of address 11.
- `start` pulsed again after 5 beats -> `err=1` one cycle later; the load continues to address 11; exactly one `done`.
- Reset asserted after 7 beats -> `we` and `busy` drop immediately; a new `start` with 12 beats writes from address 0.
- `start` coincident with the `done` cycle -> a second load begins and writes from address 0 again; `in_valid` in IDLE produces no write.
- With `SPRITE_LOADER_CHECKSUM_EN`, 12 beats of 0xFF -> `checksum=0x0BF4` at `done`.
